// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC cell.
package mac_pkg;

  localparam int DEF_A_W = 8;
  localparam int DEF_W_W = 8;
  localparam int DEF_P_W = 24;

  // Output-stationary accumulation phases.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mac_mult_add.sv
// Combinational multiply, extend, add, then saturate or wrap with overflow detect.
module mac_mult_add #(
  parameter int A_W    = 8,
  parameter int W_W    = 8,
  parameter int P_W    = 24,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic [A_W-1:0] i_a,
  input  logic [W_W-1:0] i_w,
  input  logic [P_W-1:0] i_addend,
  output logic [P_W-1:0] o_sum,
  output logic           o_ovf
);

  localparam logic SGN  = (SIGNED != 0);
  localparam int   PR_W = A_W + W_W;
  localparam int   EXT  = P_W + 1 - PR_W;

  logic [PR_W-1:0] w_a_x, w_w_x, w_prod;
  logic [P_W:0]    w_prod_x, w_add_x, w_raw;

  // Operands are extended to the full product width so the truncated
  // product is exact for both signed and unsigned interpretations.
  assign w_a_x    = {{W_W{SGN & i_a[A_W-1]}}, i_a};
  assign w_w_x    = {{A_W{SGN & i_w[W_W-1]}}, i_w};
  assign w_prod   = w_a_x * w_w_x;

  // One guard bit above P_W makes the sum exact, so overflow is just a
  // look at the top two bits (signed) or the carry (unsigned).
  assign w_prod_x = {{EXT{SGN & w_prod[PR_W-1]}}, w_prod};
  assign w_add_x  = {SGN & i_addend[P_W-1], i_addend};
  assign w_raw    = w_prod_x + w_add_x;
  assign o_ovf    = SGN ? (w_raw[P_W] ^ w_raw[P_W-1]) : w_raw[P_W];

  // Clamp to the representable range when saturating, else keep the low bits.
  always_comb begin
    o_sum = w_raw[P_W-1:0];
    if (o_ovf && (SAT != 0)) begin
      if (SGN) o_sum = w_raw[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
      else     o_sum = '1;
    end
  end

endmodule

// File: rtl/mac_cell_p.sv
// Systolic MAC cell: weight-stationary or output-stationary with double-buffered weight.
module mac_cell_p
  import mac_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int W_W    = DEF_W_W,
  parameter int P_W    = DEF_P_W,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           acc_mode,
  input  logic           dv_ain,
  input  logic [A_W-1:0] ain,
  input  logic           dv_win,
  input  logic [W_W-1:0] win,
  input  logic           init_win,
  input  logic           swap_w,
  input  logic           dv_pin,
  input  logic [P_W-1:0] pin,
  input  logic           drain,
  input  logic           clr_err,
  output logic           dv_aout,
  output logic [A_W-1:0] aout,
  output logic           dv_wout,
  output logic [W_W-1:0] wout,
  output logic           dv_pout,
  output logic [P_W-1:0] pout,
  output logic           ovf,
  output logic           coll
);

  state_t         r_state, w_state_nxt;
  logic           r_mode, w_os;
  logic [W_W-1:0] r_shadow, r_active;
  logic [P_W-1:0] r_acc, w_acc_nxt, w_pout_nxt, w_addend, w_sum;
  logic [A_W-1:0] w_a;
  logic           w_dvp_nxt, w_ovf_set, w_coll_set, w_ovf;

  // Mode is only re-read between OS transactions; mid-transaction the latched value holds.
  assign w_os     = (r_state == S_IDLE) ? acc_mode : r_mode;
  // Masking the activation makes a drain without dv_ain a pure pass-through of acc.
  assign w_a      = dv_ain ? ain : '0;
  assign w_addend = w_os ? r_acc : (dv_pin ? pin : '0);

  mac_mult_add #(
    .A_W(A_W), .W_W(W_W), .P_W(P_W), .SIGNED(SIGNED), .SAT(SAT)
  ) u_mac (
    .i_a      (w_a),
    .i_w      (r_active),
    .i_addend (w_addend),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  // State and latched mode register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_os;
    end
  end

  // Next state plus result/flag selection for both modes.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_pout_nxt  = pout;
    w_dvp_nxt   = 1'b0;
    w_ovf_set   = 1'b0;
    w_coll_set  = 1'b0;
    if (!w_os) begin
      w_state_nxt = S_IDLE;
      if (dv_ain) begin
        w_pout_nxt = w_sum;
        w_dvp_nxt  = 1'b1;
        w_ovf_set  = w_ovf;
      end
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (drain) begin
            // Own drain wins the output slot; a coincident pin is dropped.
            w_state_nxt = S_DRAIN;
            w_pout_nxt  = w_sum;
            w_dvp_nxt   = 1'b1;
            w_acc_nxt   = '0;
            w_ovf_set   = w_ovf;
            w_coll_set  = dv_pin;
          end else begin
            if (dv_ain) begin
              w_acc_nxt   = w_sum;
              w_ovf_set   = w_ovf;
              w_state_nxt = S_ACCUM;
            end
            if (dv_pin) begin
              w_pout_nxt = pin;
              w_dvp_nxt  = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          w_state_nxt = S_IDLE;
          if (dv_ain) begin
            w_acc_nxt = w_sum;
            w_ovf_set = w_ovf;
          end
          if (dv_pin) begin
            w_pout_nxt = pin;
            w_dvp_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Result, accumulator and sticky flags; a new event beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout    <= '0;
      dv_pout <= 1'b0;
      r_acc   <= '0;
      ovf     <= 1'b0;
      coll    <= 1'b0;
    end else begin
      pout    <= w_pout_nxt;
      dv_pout <= w_dvp_nxt;
      r_acc   <= w_acc_nxt;
      ovf     <= w_ovf_set  | (ovf  & ~clr_err);
      coll    <= w_coll_set | (coll & ~clr_err);
    end
  end

  // Double-buffered weight and east/south forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
      r_active <= '0;
      aout     <= '0;
      dv_aout  <= 1'b0;
      wout     <= '0;
      dv_wout  <= 1'b0;
    end else begin
      if (dv_win && init_win) r_shadow <= win;
      if (swap_w)             r_active <= r_shadow;
      aout    <= ain;
      dv_aout <= dv_ain;
      dv_wout <= dv_win & ~init_win;
      if (dv_win && !init_win) wout <= win;
    end
  end

endmodule

// File: tb/tb_mac_cell_p.sv
// Bench: three cells (unsigned sat, signed sat, unsigned wrap) on shared inputs vs an arithmetic model.
module tb_mac_cell_p;

  logic clk = 1'b0;
  logic rst, acc_mode, dv_ain, dv_win, init_win, swap_w, dv_pin, drain, clr_err;
  logic [7:0]  ain, win;
  logic [23:0] pin;
  logic        dv_aout[3], dv_wout[3], dv_pout[3], ovf[3], coll[3];
  logic [7:0]  aout[3], wout[3];
  logic [23:0] pout[3];

  int n_tests = 0, n_fail = 0;

  // Model state
  logic [7:0]  m_sh, m_act, m_aout, m_wout;
  logic        m_dva, m_dvw, m_os, m_txn, m_busy;
  logic [23:0] m_pout[3], m_acc[3];
  logic        m_dvp[3], m_ovf[3], m_coll[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mac_cell_p #(.A_W(8), .W_W(8), .P_W(24), .SIGNED(int'(g == 1)), .SAT(int'(g != 2))) u_dut (
      .clk(clk), .rst(rst), .acc_mode(acc_mode),
      .dv_ain(dv_ain), .ain(ain), .dv_win(dv_win), .win(win),
      .init_win(init_win), .swap_w(swap_w), .dv_pin(dv_pin), .pin(pin),
      .drain(drain), .clr_err(clr_err),
      .dv_aout(dv_aout[g]), .aout(aout[g]), .dv_wout(dv_wout[g]), .wout(wout[g]),
      .dv_pout(dv_pout[g]), .pout(pout[g]), .ovf(ovf[g]), .coll(coll[g]));
  end

  // True-integer a*w+p, then clamp or wrap into 24 bits.
  function automatic logic [23:0] mm(input logic [7:0] a, input logic [7:0] w,
                                     input logic [23:0] p, input bit sg, input bit sat,
                                     output bit ov);
    longint av, wv, pv, r, lo, hi;
    av = sg ? longint'($signed(a)) : longint'(a);
    wv = sg ? longint'($signed(w)) : longint'(w);
    pv = sg ? longint'($signed(p)) : longint'(p);
    r  = av * wv + pv;
    lo = sg ? -64'sd8388608 : 64'sd0;
    hi = sg ? 64'sd8388607 : 64'sd16777215;
    ov = (r < lo) || (r > hi);
    if (ov && sat) r = (r > hi) ? hi : lo;
    return r[23:0];
  endfunction

  // Advance model with the current inputs, then clock the DUTs.
  task automatic cyc();
    bit ov, os, nb;
    logic [7:0] old_sh;
    os = (m_txn || m_busy) ? m_os : acc_mode;
    nb = os && drain && !m_busy;
    for (int i = 0; i < 3; i++) begin
      ov = 0;
      if (!os) begin
        m_dvp[i] = dv_ain;
        if (dv_ain) m_pout[i] = mm(ain, m_act, dv_pin ? pin : 24'd0, i == 1, i != 2, ov);
      end else if (nb) begin
        m_pout[i] = mm(dv_ain ? ain : 8'd0, m_act, m_acc[i], i == 1, i != 2, ov);
        m_dvp[i]  = 1'b1;
        m_acc[i]  = '0;
      end else begin
        if (dv_ain) m_acc[i] = mm(ain, m_act, m_acc[i], i == 1, i != 2, ov);
        m_dvp[i] = dv_pin;
        if (dv_pin) m_pout[i] = pin;
      end
      m_ovf[i]  = ov | (m_ovf[i] & !clr_err);
      m_coll[i] = (nb & dv_pin) | (m_coll[i] & !clr_err);
      if (rst) begin
        m_pout[i] = '0; m_dvp[i] = 0; m_acc[i] = '0; m_ovf[i] = 0; m_coll[i] = 0;
      end
    end
    m_os = os;
    if (!os) begin m_txn = 0; m_busy = 0; end
    else begin
      if (nb) m_txn = 0;
      else if (dv_ain && !m_busy) m_txn = 1;
      m_busy = nb;
    end
    old_sh = m_sh;
    if (dv_win && init_win) m_sh = win;
    if (swap_w) m_act = old_sh;
    m_dvw = dv_win && !init_win;
    if (m_dvw) m_wout = win;
    m_aout = ain; m_dva = dv_ain;
    if (rst) begin
      m_sh = '0; m_act = '0; m_aout = '0; m_wout = '0; m_dva = 0; m_dvw = 0;
      m_os = 0; m_txn = 0; m_busy = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    dv_ain = 0; dv_win = 0; init_win = 0; swap_w = 0; dv_pin = 0; drain = 0; clr_err = 0;
  endtask

  task automatic load_swap(input logic [7:0] w);
    idle_in(); dv_win = 1; init_win = 1; win = w; cyc();
    idle_in(); swap_w = 1; cyc(); idle_in();
  endtask

  task automatic test_reset();
    rst = 1; acc_mode = 0; ain = 8'hA5; win = 8'h5A; pin = 24'h123456;
    idle_in(); dv_ain = 1; dv_win = 1; dv_pin = 1;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({dv_aout[i], aout[i], dv_wout[i], wout[i], dv_pout[i], pout[i], ovf[i], coll[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: outputs %b %h %b %h %b %h %b %b exp all zero", i,
                 dv_aout[i], aout[i], dv_wout[i], wout[i], dv_pout[i], pout[i], ovf[i], coll[i]);
      end
    end
    rst = 0; idle_in(); cyc();
  endtask

  task automatic test_ws_basic();
    acc_mode = 0; idle_in(); dv_win = 1; init_win = 1; win = 8'd3; cyc();
    n_tests++;
    if (dv_wout[0] !== 1'b0) begin n_fail++; $display("FAIL ws_load_nofwd: dv_wout %b exp 0", dv_wout[0]); end
    idle_in(); swap_w = 1; cyc();
    for (int k = 0; k < 3; k++) begin
      idle_in(); dv_ain = 1; ain = 8'(k); dv_pin = 1; pin = 24'(k); cyc();
      n_tests++;
      if (pout[0] !== 24'(4 * k) || dv_pout[0] !== 1'b1) begin
        n_fail++; $display("FAIL ws_basic[%0d]: pout %h/%b exp %h/1", k, pout[0], dv_pout[0], 24'(4 * k));
      end
      n_tests++;
      if (aout[0] !== 8'(k) || dv_aout[0] !== 1'b1) begin
        n_fail++; $display("FAIL ain_delay[%0d]: aout %h/%b exp %h/1", k, aout[0], dv_aout[0], 8'(k));
      end
    end
    idle_in(); cyc();
    n_tests++;
    if (dv_pout[0] !== 1'b0 || pout[0] !== 24'd8 || dv_aout[0] !== 1'b0) begin
      n_fail++; $display("FAIL ws_hold: pout %h/%b dv_aout %b exp 000008/0 0", pout[0], dv_pout[0], dv_aout[0]);
    end
  endtask

  task automatic test_wfwd();
    idle_in(); dv_win = 1; win = 8'hC3; cyc();
    n_tests++;
    if (wout[0] !== 8'hC3 || dv_wout[0] !== 1'b1) begin
      n_fail++; $display("FAIL w_fwd: wout %h/%b exp c3/1", wout[0], dv_wout[0]);
    end
    idle_in(); cyc();
    n_tests++;
    if (dv_wout[0] !== 1'b0) begin n_fail++; $display("FAIL w_fwd_end: dv_wout %b exp 0", dv_wout[0]); end
  endtask

  task automatic test_signed();
    load_swap(8'hFE);
    dv_ain = 1; ain = 8'd5; dv_pin = 1; pin = 24'd3; cyc();
    n_tests++;
    if (pout[1] !== 24'hFFFFF9 || ovf[1] !== 1'b0) begin
      n_fail++; $display("FAIL signed: pout %h ovf %b exp fffff9 0", pout[1], ovf[1]);
    end
  endtask

  task automatic test_saturate();
    load_swap(8'hFF);
    dv_ain = 1; ain = 8'hFF; dv_pin = 1; pin = 24'hFFFFF0; cyc();
    n_tests++;
    if (pout[0] !== 24'hFFFFFF || ovf[0] !== 1'b1) begin
      n_fail++; $display("FAIL sat_clamp: pout %h ovf %b exp ffffff 1", pout[0], ovf[0]);
    end
    n_tests++;
    if (pout[2] !== 24'h00FDF1 || ovf[2] !== 1'b1) begin
      n_fail++; $display("FAIL sat_wrap: pout %h ovf %b exp 00fdf1 1", pout[2], ovf[2]);
    end
    idle_in(); cyc();
    n_tests++;
    if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: ovf %b exp 1", ovf[0]); end
    clr_err = 1; cyc();
    n_tests++;
    if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: ovf %b exp 0", ovf[0]); end
    cyc(); // clr_err again with no event, keeps ovf low
    dv_ain = 1; ain = 8'hFF; dv_pin = 1; pin = 24'hFFFFF0; clr_err = 1; cyc();
    n_tests++;
    if (ovf[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: ovf %b exp 1", ovf[0]); end
    idle_in(); clr_err = 1; cyc(); idle_in();
  endtask

  task automatic test_double_buffer();
    load_swap(8'd3);
    dv_ain = 1; ain = 8'd2; dv_win = 1; init_win = 1; win = 8'd7; cyc();
    n_tests++;
    if (pout[0] !== 24'd6) begin n_fail++; $display("FAIL dbuf_stream: pout %h exp 6", pout[0]); end
    idle_in(); dv_ain = 1; ain = 8'd2; swap_w = 1; cyc();
    n_tests++;
    if (pout[0] !== 24'd6) begin n_fail++; $display("FAIL dbuf_swap_old: pout %h exp 6", pout[0]); end
    idle_in(); dv_ain = 1; ain = 8'd2; cyc();
    n_tests++;
    if (pout[0] !== 24'd14) begin n_fail++; $display("FAIL dbuf_new: pout %h exp e", pout[0]); end
    // load and swap together: active takes the old shadow (7), shadow takes 9
    idle_in(); dv_win = 1; init_win = 1; win = 8'd9; swap_w = 1; cyc();
    idle_in(); dv_ain = 1; ain = 8'd1; cyc();
    n_tests++;
    if (pout[0] !== 24'd7) begin n_fail++; $display("FAIL load_swap_same: pout %h exp 7", pout[0]); end
    idle_in(); swap_w = 1; cyc();
    idle_in(); dv_ain = 1; ain = 8'd1; cyc();
    n_tests++;
    if (pout[0] !== 24'd9) begin n_fail++; $display("FAIL load_swap_next: pout %h exp 9", pout[0]); end
    idle_in();
  endtask

  // Random stimulus; mode toggling is enabled by os_mix.
  task automatic test_random(input string tag, input bit os_mix, input int n);
    for (int c = 0; c < n; c++) begin
      dv_ain = 1'($urandom); ain = 8'($urandom);
      dv_win = ($urandom % 4 == 0); init_win = 1'($urandom); win = 8'($urandom);
      swap_w = ($urandom % 6 == 0);
      dv_pin = os_mix ? ($urandom % 4 == 0) : 1'($urandom);
      pin = ($urandom % 3 == 0) ? (24'hFF0000 | 24'($urandom % 65536)) : 24'($urandom);
      drain = os_mix && ($urandom % 6 == 0);
      clr_err = ($urandom % 10 == 0);
      if (os_mix && ($urandom % 12 == 0)) acc_mode = ~acc_mode;
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (pout[i] !== m_pout[i] || dv_pout[i] !== m_dvp[i] || ovf[i] !== m_ovf[i] || coll[i] !== m_coll[i]) begin
          n_fail++;
          $display("FAIL %s[%0d] cyc %0d: pout/dv/ovf/coll %h/%b/%b/%b exp %h/%b/%b/%b", tag, i, c,
                   pout[i], dv_pout[i], ovf[i], coll[i], m_pout[i], m_dvp[i], m_ovf[i], m_coll[i]);
        end
      end
      n_tests++;
      if (aout[0] !== m_aout || dv_aout[0] !== m_dva || wout[0] !== m_wout || dv_wout[0] !== m_dvw) begin
        n_fail++;
        $display("FAIL %s_fwd cyc %0d: a %h/%b w %h/%b exp %h/%b %h/%b", tag, c,
                 aout[0], dv_aout[0], wout[0], dv_wout[0], m_aout, m_dva, m_wout, m_dvw);
      end
    end
    idle_in(); clr_err = 1; cyc(); cyc(); idle_in();
  endtask

  task automatic test_os();
    acc_mode = 1; load_swap(8'd4);
    for (int k = 1; k <= 3; k++) begin
      dv_ain = 1; ain = 8'(k); cyc();
      n_tests++;
      if (dv_pout[0] !== 1'b0) begin n_fail++; $display("FAIL os_accum[%0d]: dv_pout %b exp 0", k, dv_pout[0]); end
    end
    idle_in(); drain = 1; cyc();
    n_tests++;
    if (pout[0] !== 24'd24 || dv_pout[0] !== 1'b1) begin
      n_fail++; $display("FAIL os_drain: pout %h/%b exp 18/1", pout[0], dv_pout[0]);
    end
    idle_in(); cyc();
    n_tests++;
    if (dv_pout[0] !== 1'b0) begin n_fail++; $display("FAIL os_drain_once: dv_pout %b exp 0", dv_pout[0]); end
    dv_pin = 1; pin = 24'h00ABCD; cyc();
    n_tests++;
    if (pout[0] !== 24'h00ABCD || dv_pout[0] !== 1'b1) begin
      n_fail++; $display("FAIL os_chain: pout %h/%b exp 00abcd/1", pout[0], dv_pout[0]);
    end
    idle_in(); dv_ain = 1; ain = 8'd1; cyc();
    idle_in(); drain = 1; dv_pin = 1; pin = 24'h000123; cyc();
    n_tests++;
    if (pout[0] !== 24'd4 || dv_pout[0] !== 1'b1 || coll[0] !== 1'b1) begin
      n_fail++; $display("FAIL os_coll: pout %h/%b coll %b exp 000004/1 1", pout[0], dv_pout[0], coll[0]);
    end
    idle_in(); clr_err = 1; cyc(); idle_in();
  endtask

  task automatic test_mode_switch();
    acc_mode = 1; dv_ain = 1; ain = 8'd1; cyc();
    acc_mode = 0; cyc();
    n_tests++;
    if (dv_pout[0] !== 1'b0) begin n_fail++; $display("FAIL mode_latched: dv_pout %b exp 0", dv_pout[0]); end
    idle_in(); drain = 1; cyc();
    n_tests++;
    if (pout[0] !== 24'd8 || dv_pout[0] !== 1'b1) begin
      n_fail++; $display("FAIL mode_drain: pout %h/%b exp 000008/1", pout[0], dv_pout[0]);
    end
    idle_in(); cyc();
    dv_ain = 1; ain = 8'd1; cyc();
    n_tests++;
    if (pout[0] !== 24'd4 || dv_pout[0] !== 1'b1) begin
      n_fail++; $display("FAIL mode_ws_after: pout %h/%b exp 000004/1", pout[0], dv_pout[0]);
    end
    idle_in(); cyc();
  endtask

  task automatic test_rst_mid_accum();
    acc_mode = 1; load_swap(8'd4);
    dv_ain = 1; ain = 8'd5; cyc(); cyc();
    idle_in(); rst = 1; cyc();
    n_tests++;
    if (dv_pout[0] !== 1'b0 || ovf[0] !== 1'b0 || coll[0] !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: dv_pout %b ovf %b coll %b exp 0 0 0", dv_pout[0], ovf[0], coll[0]);
    end
    rst = 0; acc_mode = 1; drain = 1; cyc();
    n_tests++;
    if (pout[0] !== 24'd0 || dv_pout[0] !== 1'b1) begin
      n_fail++; $display("FAIL rst_drain: pout %h/%b exp 000000/1", pout[0], dv_pout[0]);
    end
    idle_in(); cyc();
  endtask

  initial begin
    m_pout = '{default: '0}; m_acc = '{default: '0};
    m_dvp = '{default: 0}; m_ovf = '{default: 0}; m_coll = '{default: 0};
    m_sh = '0; m_act = '0; m_aout = '0; m_wout = '0; m_dva = 0; m_dvw = 0;
    m_os = 0; m_txn = 0; m_busy = 0;
    test_reset();
    test_ws_basic();
    test_wfwd();
    test_signed();
    test_saturate();
    test_double_buffer();
    acc_mode = 0;
    test_random("ws_rand", 1'b0, 200);
    test_os();
    test_mode_switch();
    test_rst_mid_accum();
    acc_mode = 1;
    test_random("os_rand", 1'b1, 400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
